// File: rtl/fifo8x9_ctrl.sv
// Control FSM for an 8-entry x 9-bit buffer. It issues the buffer strobes,
// tracks occupancy and holds sticky overflow/underflow flags.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_INIT  | after reset: clear both buffer pointers and count, no acks
// S_RUN   | normal operation: accept push/pop against current full/empty
// S_FLUSH | clear both pointers and count; repeats while flush is held
module fifo8x9_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             wren,
  output logic             WrInc,
  output logic             rden,
  output logic             RdInc,
  output logic             WrPtrClr,
  output logic             RdPtrClr,
  output logic             push_ack,
  output logic             pop_ack,
  output logic             dout_valid,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             udf_err
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_valid_q;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             clr;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_FLUSH;
      S_FLUSH: state_d = flush ? S_FLUSH : S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Strobes are gated by rst so the buffer sees nothing while reset is held.
  always_comb begin
    push_ack = 1'b0;
    pop_ack  = 1'b0;
    clr      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_INIT:  clr = 1'b1;
        S_RUN: begin
          if (!flush) begin
            push_ack = push & ~full;
            pop_ack  = pop & ~empty;
          end
        end
        S_FLUSH: clr = 1'b1;
        default: clr = 1'b0;
      endcase
    end
  end

  assign wren     = push_ack;
  assign WrInc    = push_ack;
  assign rden     = pop_ack;
  assign RdInc    = pop_ack;
  assign WrPtrClr = clr;
  assign RdPtrClr = clr;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    case (state_q)
      S_RUN: begin
        count_d = count_q + {{(CNT_W-1){1'b0}}, push_ack}
                          - {{(CNT_W-1){1'b0}}, pop_ack};
        if (!flush && push && full)  ovf_d = 1'b1;
        if (!flush && pop  && empty) udf_d = 1'b1;
      end
      default: count_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= pop_ack;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  assign count      = count_q;
  assign dout_valid = dout_valid_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: a behavioural 8x9 buffer driven by the controller
// strobes, a data scoreboard, and a vector table of expected control outputs.
module tb_fifo8x9_ctrl;

  logic       clk, rst, push, pop, flush;
  logic       wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr;
  logic       push_ack, pop_ack, dout_valid, full, empty, ovf_err, udf_err;
  logic [3:0] count;

  logic [8:0] din, dout;
  logic [8:0] mem [8];
  logic [2:0] wp, rp;
  logic [8:0] din_next;
  logic [8:0] sb [$];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic push, pop, flush;
    logic pa, ka, clr, dv, ovf, udf;
    int   cnt;
  } vec_t;

  vec_t tbl [$];

  fifo8x9_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wren(wren), .WrInc(WrInc), .rden(rden), .RdInc(RdInc),
    .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr),
    .push_ack(push_ack), .pop_ack(pop_ack), .dout_valid(dout_valid),
    .count(count), .full(full), .empty(empty),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural buffer: 3-bit pointers wrap naturally, registered read.
  always @(posedge clk) begin
    if (wren) mem[wp] <= din;
    if (WrPtrClr) wp <= 3'd0;
    else if (WrInc) wp <= wp + 3'd1;
    if (rden) dout <= mem[rp];
    if (RdPtrClr) rp <= 3'd0;
    else if (RdInc) rp <= rp + 3'd1;
  end

  function automatic vec_t mk(logic p, logic q, logic f, logic pa, logic ka,
                              logic clr, logic dv, logic ovf, logic udf, int cnt);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f;
    v.pa = pa; v.ka = ka; v.clr = clr; v.dv = dv;
    v.ovf = ovf; v.udf = udf; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called just after a negedge: drive, check away from the edge, clock once.
  task automatic run_vec(vec_t v, string tag);
    logic [8:0] e;
    push  = v.push;
    pop   = v.pop;
    flush = v.flush;
    din   = din_next;
    #1;
    chk({tag, " push_ack"}, int'(push_ack), int'(v.pa));
    chk({tag, " wren"},     int'(wren),     int'(v.pa));
    chk({tag, " WrInc"},    int'(WrInc),    int'(v.pa));
    chk({tag, " pop_ack"},  int'(pop_ack),  int'(v.ka));
    chk({tag, " rden"},     int'(rden),     int'(v.ka));
    chk({tag, " RdInc"},    int'(RdInc),    int'(v.ka));
    chk({tag, " WrPtrClr"}, int'(WrPtrClr), int'(v.clr));
    chk({tag, " RdPtrClr"}, int'(RdPtrClr), int'(v.clr));
    chk({tag, " count"},    int'(count),    v.cnt);
    chk({tag, " full"},     int'(full),     int'(v.cnt == 8));
    chk({tag, " empty"},    int'(empty),    int'(v.cnt == 0));
    chk({tag, " dout_valid"}, int'(dout_valid), int'(v.dv));
    chk({tag, " ovf_err"},  int'(ovf_err),  int'(v.ovf));
    chk({tag, " udf_err"},  int'(udf_err),  int'(v.udf));
    if (dout_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s data: got %0h expected none (scoreboard empty)", tag, dout);
      end else begin
        e = sb.pop_front();
        chk({tag, " data"}, int'(dout), int'(e));
      end
    end
    if (WrPtrClr) sb.delete();
    if (push_ack) begin
      sb.push_back(din);
      din_next = din_next + 9'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    din = '0; din_next = 9'h101;

    // Reset then idle, fill 8, overflow, drain 8, underflow with push.
    tbl.push_back(mk(1,0,0, 0,0,1, 0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 0,0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1,0,0, 1,0,0, 0, 0,0, i));
    tbl.push_back(mk(1,0,0, 0,0,0, 0, 0,0, 8));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,0, 8));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0,1,0, 0,1,0, i > 0, 1,0, 8 - i));
    tbl.push_back(mk(0,0,0, 0,0,0, 1, 1,0, 0));
    tbl.push_back(mk(1,1,0, 1,0,0, 0, 1,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 1,1, 1));

    @(negedge clk);
    #1;
    chk("rst count",      int'(count),      0);
    chk("rst empty",      int'(empty),      1);
    chk("rst full",       int'(full),       0);
    chk("rst WrPtrClr",   int'(WrPtrClr),   0);
    chk("rst dout_valid", int'(dout_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // Bring occupancy to 4, then 12 simultaneous push/pop cycles (pointers wrap).
    for (int i = 1; i < 4; i++) run_vec(mk(1,0,0, 1,0,0, 0, 1,1, i), $sformatf("fill%0d", i));
    for (int i = 0; i < 12; i++)
      run_vec(mk(1,1,0, 1,1,0, i > 0, 1,1, 4), $sformatf("pp%0d", i));

    // Reach 5 with a pop just before, then flush with push and pop high.
    run_vec(mk(1,0,0, 1,0,0, 1, 1,1, 4), "to5a");
    run_vec(mk(1,0,0, 1,0,0, 0, 1,1, 5), "to5b");
    run_vec(mk(0,1,0, 0,1,0, 0, 1,1, 6), "to5c");
    run_vec(mk(1,1,1, 0,0,0, 1, 1,1, 5), "flush_take");
    run_vec(mk(0,0,0, 0,0,1, 0, 1,1, 5), "flush_state");
    run_vec(mk(0,0,0, 0,0,0, 0, 1,1, 0), "flush_done");

    // Flush held for two cycles keeps the FSM in FLUSH.
    run_vec(mk(0,0,1, 0,0,0, 0, 1,1, 0), "hold0");
    run_vec(mk(1,1,1, 0,0,1, 0, 1,1, 0), "hold1");
    run_vec(mk(0,0,0, 0,0,1, 0, 1,1, 0), "hold2");
    run_vec(mk(0,0,0, 0,0,0, 0, 1,1, 0), "hold3");

    // Asynchronous reset in the middle of a cycle discards occupancy.
    run_vec(mk(1,0,0, 1,0,0, 0, 1,1, 0), "pre_rst0");
    run_vec(mk(1,0,0, 1,0,0, 0, 1,1, 1), "pre_rst1");
    push = 1'b1; pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst count",    int'(count),    0);
    chk("mid_rst empty",    int'(empty),    1);
    chk("mid_rst push_ack", int'(push_ack), 0);
    chk("mid_rst wren",     int'(wren),     0);
    chk("mid_rst WrPtrClr", int'(WrPtrClr), 0);
    chk("mid_rst ovf_err",  int'(ovf_err),  0);
    chk("mid_rst udf_err",  int'(udf_err),  0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(mk(1,1,0, 0,0,1, 0, 0,0, 0), "post_rst_init");
    run_vec(mk(0,0,0, 0,0,0, 0, 0,0, 0), "post_rst_run");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
